// File: rtl/vec_pkg.sv
// Shared types and defaults for the vector execute stage.
package vec_pkg;

    localparam int unsigned VecWidth = 32;
    localparam int unsigned VecDepth = 4;
    localparam int unsigned VecTagW  = 4;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpShl = 3'b101,
        OpShr = 3'b110,
        OpMul = 3'b111
    } vec_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StWait
    } vec_state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU covering every op except MUL.
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH = VecWidth
) (
    input  vec_op_e            op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   y_o
);

    localparam int unsigned ShW = $clog2(WIDTH);

    logic [ShW-1:0] shamt;

    // Only the low bits of operand B select the shift distance.
    assign shamt = b_i[ShW-1:0];

    // Element-wise result; MUL is handled by the shared multiplier in the top.
    always_comb begin
        y_o = '0;
        case (op_i)
            OpAdd:   y_o = a_i + b_i;
            OpSub:   y_o = a_i - b_i;
            OpAnd:   y_o = a_i & b_i;
            OpOr:    y_o = a_i | b_i;
            OpXor:   y_o = a_i ^ b_i;
            OpShl:   y_o = a_i << shamt;
            OpShr:   y_o = a_i >> shamt;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/vec_exec_unit.sv
// Vector execute stage: parallel single-cycle ALU ops, lane-serial MUL on one
// shared multiplier, registered result with valid/ready on both sides.
module vec_exec_unit
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH = VecWidth,
    parameter int unsigned DEPTH = VecDepth,
    parameter int unsigned TAGW  = VecTagW
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] srca_i   [0:DEPTH-1],
    input  logic [WIDTH-1:0] srcb_i   [0:DEPTH-1],
    input  logic [TAGW-1:0]  rd_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o [0:DEPTH-1],
    output logic [TAGW-1:0]  rd_out_o,
    output logic             busy_o
);

    // Counter runs one past the last lane so the final lane settles before retiring.
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam int unsigned LaneW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    vec_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q [0:DEPTH-1];
    logic [WIDTH-1:0] opa_d [0:DEPTH-1];
    logic [WIDTH-1:0] opb_q [0:DEPTH-1];
    logic [WIDTH-1:0] opb_d [0:DEPTH-1];
    logic [WIDTH-1:0] acc_q [0:DEPTH-1];
    logic [WIDTH-1:0] acc_d [0:DEPTH-1];
    logic [TAGW-1:0]  mul_rd_q, mul_rd_d;
    logic [WIDTH-1:0] res_q [0:DEPTH-1];
    logic [WIDTH-1:0] res_d [0:DEPTH-1];
    logic [TAGW-1:0]  rd_q, rd_d;
    logic             out_valid_q, out_valid_d;

    vec_op_e          op;
    logic [WIDTH-1:0] alu_y [0:DEPTH-1];
    logic [LaneW-1:0] lane_sel;
    logic [WIDTH-1:0] mul_lo;
    logic             slot_free;
    logic             in_ready;
    logic             accept;

    assign op = vec_op_e'(op_i);

    for (genvar g = 0; g < DEPTH; g++) begin : g_lane
        vec_lane_alu #(
            .WIDTH (WIDTH)
        ) u_lane_alu (
            .op_i (op),
            .a_i  (srca_i[g]),
            .b_i  (srcb_i[g]),
            .y_o  (alu_y[g])
        );
    end

    // Shared multiplier; low WIDTH bits of the product are kept.
    assign lane_sel = cnt_q[LaneW-1:0];
    assign mul_lo   = opa_q[lane_sel] * opb_q[lane_sel];

    assign slot_free = !out_valid_q || out_ready_i;
    assign in_ready  = (state_q == StIdle) && !reset_i && !flush_i && slot_free;
    assign accept    = in_valid_i && in_ready;

    // Next-state: accept, lane-serial MUL, retire into the output slot, flush abort.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        mul_rd_d    = mul_rd_q;
        res_d       = res_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q && !out_ready_i;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (op == OpMul) begin
                        opa_d    = srca_i;
                        opb_d    = srcb_i;
                        mul_rd_d = rd_in_i;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        res_d       = alu_y;
                        rd_d        = rd_in_i;
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                if (cnt_q == CntW'(DEPTH)) begin
                    if (slot_free) begin
                        res_d       = acc_q;
                        rd_d        = mul_rd_q;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StIdle;
                    end else begin
                        state_d = StWait;
                    end
                end else begin
                    acc_d[lane_sel] = mul_lo;
                    cnt_d           = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                if (slot_free) begin
                    res_d       = acc_q;
                    rd_d        = mul_rd_q;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Flush drops the output slot and any MUL in flight; data registers keep their value.
        if (flush_i) begin
            state_d     = StIdle;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            opa_q       <= '{default: '0};
            opb_q       <= '{default: '0};
            acc_q       <= '{default: '0};
            mul_rd_q    <= '0;
            res_q       <= '{default: '0};
            rd_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            mul_rd_q    <= mul_rd_d;
            res_q       <= res_d;
            rd_q        <= rd_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign result_o    = res_q;
    assign rd_out_o    = rd_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_vec_exec_unit.sv
// Bench for vec_exec_unit: directed scenarios plus random traffic, all checked
// against a transaction-level model of the stage (output slot + MUL in flight).
module tb_vec_exec_unit;

    localparam int W = 32;
    localparam int D = 4;
    localparam int T = 4;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] srca   [0:D-1];
    logic [W-1:0] srcb   [0:D-1];
    logic [T-1:0] rd_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result [0:D-1];
    logic [T-1:0] rd_out;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one output slot and at most one MUL in flight.
    bit           m_slot_valid;
    logic [W-1:0] m_slot_data [0:D-1];
    logic [T-1:0] m_slot_tag;
    bit           m_mul_active;
    int           m_mul_edges;
    logic [W-1:0] m_mul_data [0:D-1];
    logic [T-1:0] m_mul_tag;

    vec_exec_unit #(
        .WIDTH (W),
        .DEPTH (D),
        .TAGW  (T)
    ) u_dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .srca_i      (srca),
        .srcb_i      (srcb),
        .rd_in_i     (rd_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .rd_out_o    (rd_out),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference semantics in plain 64-bit arithmetic, reduced modulo 2^32.
    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        longint unsigned x, y, m;
        x = a;
        y = b;
        m = 64'h1_0000_0000;
        case (o)
            3'd0:    return 32'((x + y) % m);
            3'd1:    return 32'((x + m - y) % m);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return 32'((x << (y % 32)) % m);
            3'd6:    return 32'(x >> (y % 32));
            default: return 32'((x * y) % m);
        endcase
    endfunction

    // Compare DUT against the model for this cycle, advance the model, cross one edge.
    task automatic tick();
        logic [W-1:0] calc [0:D-1];
        bit exp_rdy;
        bit free;
        bit acc;
        #1;
        exp_rdy = !reset && !flush && !m_mul_active && (!m_slot_valid || out_ready);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("busy", busy, m_mul_active);
        check_eq("out_valid", out_valid, m_slot_valid);
        if (m_slot_valid) begin
            for (int i = 0; i < D; i++) check_eq("result", result[i], m_slot_data[i]);
            check_eq("rd_out", rd_out, m_slot_tag);
        end
        free = !m_slot_valid || out_ready;
        acc  = in_valid && exp_rdy;
        for (int i = 0; i < D; i++) calc[i] = ref_op(op, srca[i], srcb[i]);
        if (reset) begin
            m_slot_valid = 0;
            m_mul_active = 0;
            for (int i = 0; i < D; i++) m_slot_data[i] = '0;
            m_slot_tag = '0;
        end else if (flush) begin
            m_slot_valid = 0;
            m_mul_active = 0;
        end else begin
            if (m_slot_valid && out_ready) m_slot_valid = 0;
            if (m_mul_active) begin
                // Result may land on the (DEPTH+1)-th edge after accept, or later if blocked.
                if (m_mul_edges + 1 >= D + 1 && free) begin
                    m_slot_valid = 1;
                    m_slot_data  = m_mul_data;
                    m_slot_tag   = m_mul_tag;
                    m_mul_active = 0;
                end else begin
                    m_mul_edges++;
                end
            end
            if (acc) begin
                if (op == 3'd7) begin
                    m_mul_active = 1;
                    m_mul_edges  = 0;
                    m_mul_data   = calc;
                    m_mul_tag    = rd_in;
                end else begin
                    m_slot_valid = 1;
                    m_slot_data  = calc;
                    m_slot_tag   = rd_in;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic set_ops(input logic [2:0] o, input logic [T-1:0] tag);
        op       = o;
        rd_in    = tag;
        in_valid = 1'b1;
    endtask

    int lat;

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = '0;
        rd_in     = '0;
        out_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
            srca[i] = '0;
            srcb[i] = '0;
        end
        m_slot_valid = 0;
        m_mul_active = 0;
        m_mul_edges  = 0;
        m_slot_tag   = '0;
        m_mul_tag    = '0;
        for (int i = 0; i < D; i++) begin
            m_slot_data[i] = '0;
            m_mul_data[i]  = '0;
        end
        @(posedge clk);
        #1;
        tick();
        for (int i = 0; i < D; i++) check_eq("rst_result", result[i], 0);
        check_eq("rst_rd_out", rd_out, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;

        // ADD: lanes i + (i+4)
        for (int i = 0; i < D; i++) begin
            srca[i] = W'(i);
            srcb[i] = W'(i + 4);
        end
        set_ops(3'd0, 4'd3);
        tick();
        in_valid = 1'b0;
        check_eq("add_valid_next", out_valid, 1);
        for (int i = 0; i < D; i++) check_eq("add_lane", result[i], 64'(4 + 2 * i));
        check_eq("add_tag", rd_out, 3);
        tick();

        // SUB wrap
        for (int i = 0; i < D; i++) begin
            srca[i] = '0;
            srcb[i] = 32'd1;
        end
        set_ops(3'd1, 4'd5);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < D; i++) check_eq("sub_wrap", result[i], 32'hFFFF_FFFF);

        // SHR with upper shift bits ignored
        for (int i = 0; i < D; i++) begin
            srca[i] = 32'h8000_0000;
            srcb[i] = 32'h21;
        end
        set_ops(3'd6, 4'd6);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < D; i++) check_eq("shr_mask", result[i], 32'h4000_0000);
        tick();

        // MUL latency and values
        for (int i = 0; i < D; i++) begin
            srca[i] = W'(i + 4);
            srcb[i] = W'(i + 8);
        end
        set_ops(3'd7, 4'd9);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check_eq("mul_latency", lat, D + 1);
        check_eq("mul_lane0", result[0], 32);
        check_eq("mul_lane1", result[1], 45);
        check_eq("mul_lane2", result[2], 60);
        check_eq("mul_lane3", result[3], 77);
        tick();

        // MUL keeps only low bits
        for (int i = 0; i < D; i++) begin
            srca[i] = 32'h1_0000;
            srcb[i] = 32'h1_0000;
        end
        set_ops(3'd7, 4'd10);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        for (int i = 0; i < D; i++) check_eq("mul_wrap", result[i], 0);
        tick();

        // Backpressure: held ADD result blocks a pending MUL
        out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            srca[i] = W'(3 * i);
            srcb[i] = 32'd1;
        end
        set_ops(3'd0, 4'd1);
        tick();
        set_ops(3'd7, 4'd2);
        for (int k = 0; k < 3; k++) tick();
        check_eq("bp_hold", result[0], 1);
        check_eq("bp_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("bp_swap_busy", busy, 1);
        wait_out(lat);
        tick();

        // Back-to-back ADDs at full rate
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < D; i++) begin
                srca[i] = $urandom;
                srcb[i] = $urandom;
            end
            set_ops(3'd0, T'(k));
            tick();
            check_eq("b2b_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        tick();

        // MUL finishing while downstream stalls
        out_ready = 1'b0;
        for (int i = 0; i < D; i++) begin
            srca[i] = $urandom;
            srcb[i] = $urandom;
        end
        set_ops(3'd7, 4'd7);
        tick();
        in_valid = 1'b0;
        wait_out(lat);
        check_eq("mul_stall_lat", lat, D + 1);
        for (int k = 0; k < 3; k++) tick();
        out_ready = 1'b1;
        tick();

        // Flush at lane 2, with an ADD presented in the flush cycle
        set_ops(3'd7, 4'd4);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        set_ops(3'd0, 4'd8);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_busy", busy, 0);
        for (int i = 0; i < D; i++) begin
            srca[i] = W'(100 + i);
            srcb[i] = W'(7);
        end
        set_ops(3'd0, 4'd11);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < D; i++) check_eq("post_flush_add", result[i], 64'(107 + i));
        tick();

        // Reset at lane 1
        set_ops(3'd7, 4'd12);
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rstmul_valid", out_valid, 0);
        check_eq("rstmul_busy", busy, 0);
        check_eq("rstmul_result", result[2], 0);
        for (int i = 0; i < D; i++) begin
            srca[i] = W'(i * 11);
            srcb[i] = W'(i);
        end
        set_ops(3'd0, 4'd13);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < D; i++) check_eq("post_rst_add", result[i], 64'(12 * i));
        tick();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            op        = 3'($urandom_range(0, 7));
            rd_in     = T'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            for (int i = 0; i < D; i++) begin
                srca[i] = $urandom;
                srcb[i] = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 63)) : $urandom;
            end
            tick();
        end
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < D + 3; k++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_exec_unit.md
# vec_exec_unit

- Vector execute stage that consumes the forwarded operands produced by the three-way vector forwarding muxes (srca/srcb, DEPTH lanes of WIDTH bits each).
- Applies one element-wise operation to all lanes and registers the result for the writeback/memory stage, with valid/ready handshakes on both sides.
- Single-cycle ops run on all lanes in parallel.
- MUL reuses one shared multiplier across lanes, one lane per cycle, and stalls upstream while it runs.

## Interface
- WIDTH, 32, bits per vector element
- DEPTH, 4, lanes per vector
- TAGW, 4, destination register tag width
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  pipeline flush, synchronous
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  unit accepts this cycle
- op  in  3  operation code (see Operation)
- srca  in  WIDTH x DEPTH (unpacked [0:DEPTH-1])  operand A lanes
- srcb  in  WIDTH x DEPTH (unpacked [0:DEPTH-1])  operand B lanes
- rd_in  in  TAGW  destination tag, passed through
- out_valid  out  1  result register holds a result
- out_ready  in  1  downstream consumes the result
- result  out  WIDTH x DEPTH (unpacked [0:DEPTH-1])  result lanes
- rd_out  out  TAGW  tag of result
- busy  out  1  multi-cycle MUL in progress or waiting to retire

## Operation
- Op codes: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- Arithmetic is modulo 2^WIDTH; MUL keeps the low WIDTH bits of the product.
- Shift amount is srcb[i][$clog2(WIDTH)-1:0]; upper bits are ignored.
- Handshake:
  - Accept occurs when in_valid && in_ready.
  - Retire occurs when out_valid && out_ready.
  - Operands and tag are sampled at accept and need not be held afterwards.
- in_ready = state==IDLE && !reset && !flush && (!out_valid || out_ready).
- States:
  - IDLE:
    - ALU op accepted → result/rd_out loaded, out_valid=1, stay IDLE.
    - MUL accepted → operands latched, lane counter=0, go MUL.
  - MUL:
    - Each cycle computes lane[cnt] into an internal accumulator, cnt++.
    - After lane DEPTH-1: if output slot is free (!out_valid || out_ready), load result, out_valid=1, go IDLE; else go WAIT.
  - WAIT: when the output slot is free, load result, out_valid=1, go IDLE.
- busy=1 in MUL and WAIT.
- Output register holds its value while out_valid && !out_ready.
- flush:
  - Clears out_valid.
  - Aborts MUL/WAIT back to IDLE, discarding the partial result.
  - Blocks accept that cycle.
  - result/rd_out data are not cleared.
- Reset takes priority over flush. Reset mid-MUL aborts identically to flush.

## Timing
- Reset values: out_valid=0, result lanes all 0, rd_out=0, busy=0, state=IDLE, lane counter=0, in_ready=0 while reset is high.
- ALU latency is 1: accept at edge N → out_valid high after edge N, i.e. visible in cycle N+1.
- ALU throughput is one op/cycle when out_ready=1.
- MUL latency is DEPTH+1 edges: accept at edge N, lanes computed at edges N+1..N+DEPTH, out_valid high after edge N+DEPTH+1 if the slot is free.
- in_ready is low from the cycle after a MUL accept until the MUL retires into the output register.
- Retire and accept in the same cycle are legal: the new result replaces the old with no bubble.
- out_valid=1 with out_ready=0 → in_ready=0. Nothing is dropped or overwritten.

## Structure
- vec_pkg holds:
  - vec_op_e enum (the 8 codes above).
  - Default WIDTH/DEPTH/TAGW constants.
  - State enum {IDLE, MUL, WAIT}.
- Sub-module vec_lane_alu: combinational single-lane ALU for ops 000–110, instantiated DEPTH times.
- The shared multiplier and lane counter live in the top.

## Test plan
- Reset then ADD:
  - Stimulus: WIDTH=32, DEPTH=4, srca[i]=i, srcb[i]=i+4, out_ready=1.
  - Response: after reset, in_ready=1, busy=0. After the ADD, result={4,6,8,10}, out_valid exactly 1 cycle after accept.
- SUB wrap and SHR masking:
  - SUB with a=0, b=1 in all lanes → 0xFFFFFFFF each lane.
  - SHR with a=0x80000000, b=0x21 → 0x40000000 (shift 1).
- MUL:
  - Stimulus: srca[i]=i+4, srcb[i]=i+8.
  - Response: in_ready low, busy high for the run. out_valid rises DEPTH+1 edges after accept. result={32,45,60,77}. MUL 0x10000×0x10000 → 0.
- Backpressure:
  - Stimulus: out_ready=0 after an ADD; issue a MUL.
  - Response: result held stable and in_ready=0. Once out_ready=1, retire and accept coincide; back-to-back ADDs sustain 1/cycle.
- MUL into full slot:
  - Stimulus: out_ready=0 while a MUL finishes.
  - Response: state WAIT, busy=1. MUL result appears the cycle after out_ready rises.
- Flush/reset mid-MUL:
  - Stimulus: flush at lane 2; separately, reset at lane 1.
  - Response: out_valid=0, busy=0, IDLE next cycle. The next ADD returns correct values with no stale lanes.
